// File: rtl/point_packer.sv
// Packs a stream of DATA_W-bit point records into LANES-wide words (record 0 in the low bits).
// A flush emits a partially filled word with its lane count and pulses done once that word drains.
module point_packer #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned LANES  = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [DATA_W*LANES-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2:0]                out_count,
    output logic                      done
);

    localparam int unsigned OUT_W  = DATA_W * LANES;
    localparam int unsigned CNT_W  = $clog2(LANES + 1);
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LANES);

    logic [LANES-1:0][DATA_W-1:0] asm_q, asm_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         flush_pend_q, flush_pend_d;
    logic                         flush_word_q, flush_word_d;
    logic [OUT_W-1:0]             out_data_d;
    logic [2:0]                   out_count_d;
    logic                         out_valid_d;
    logic                         done_d;

    logic accept;
    logic slot_free;
    logic out_hs;

    // Ready depends only on registered state so upstream sees no combinational path from out_ready.
    assign in_ready  = (cnt_q < FULL_CNT) && !flush_pend_q;
    assign accept    = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;
    assign out_hs    = out_valid && out_ready;

    always_comb begin
        asm_d        = asm_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q | flush;
        flush_word_d = flush_word_q;
        out_data_d   = out_data;
        out_count_d  = out_count;
        out_valid_d  = out_valid;
        done_d       = out_hs && flush_word_q;

        if (out_hs) begin
            out_valid_d  = 1'b0;
            flush_word_d = 1'b0;
        end

        if (accept) begin
            asm_d[LANE_W'(cnt_q)] = in_data;
            cnt_d                 = cnt_q + CNT_W'(1);
        end

        // Flush pending blocks new beats, so its resolution never races an accept.
        if (flush_pend_q && slot_free) begin
            flush_pend_d = 1'b0;
            if (cnt_q != '0) begin
                out_data_d   = asm_q;
                out_count_d  = 3'(cnt_q);
                out_valid_d  = 1'b1;
                flush_word_d = 1'b1;
                asm_d        = '0;
                cnt_d        = '0;
            end else begin
                done_d = 1'b1;
            end
        end else if ((cnt_d == FULL_CNT) && slot_free) begin
            out_data_d  = asm_d;
            out_count_d = 3'(FULL_CNT);
            out_valid_d = 1'b1;
            asm_d       = '0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            asm_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            flush_word_q <= 1'b0;
            out_data     <= '0;
            out_count    <= '0;
            out_valid    <= 1'b0;
            done         <= 1'b0;
        end else begin
            asm_q        <= asm_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            flush_word_q <= flush_word_d;
            out_data     <= out_data_d;
            out_count    <= out_count_d;
            out_valid    <= out_valid_d;
            done         <= done_d;
        end
    end

endmodule

// File: tb/tb_point_packer.sv
// Scoreboard bench for point_packer: a record-level packing model feeds expected words,
// which are compared against every output handshake; timing of ready/valid/done is checked directly.
module tb_point_packer;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned LANES  = 4;
    localparam int unsigned OUT_W  = DATA_W * LANES;
    localparam logic [511:0] ONE  = 512'd1;
    localparam logic [511:0] ZERO = 512'd0;

    logic               clk;
    logic               reset_n;
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic               flush;
    logic [OUT_W-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [2:0]         out_count;
    logic               done;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [2:0]       count;
    } exp_t;

    exp_t                          sb[$];
    logic [LANES-1:0][DATA_W-1:0]  m_lanes;
    int                            m_cnt;
    int                            n_checks;
    int                            n_pass;
    int                            done_seen;

    point_packer #(.DATA_W(DATA_W), .LANES(LANES)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rnd_rec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference model and output scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset_n) begin
            m_lanes = '0;
            m_cnt   = 0;
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("sb_nonempty", 512'(sb.size() != 0), ONE);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("word_data", 512'(out_data), 512'(e.data));
                    check("word_count", 512'(out_count), 512'(e.count));
                end
            end
            if (done) done_seen++;
            if (in_valid && in_ready) begin
                m_lanes[m_cnt] = in_data;
                m_cnt++;
                if (m_cnt == LANES) begin
                    sb.push_back('{data: m_lanes, count: 3'(LANES)});
                    m_lanes = '0;
                    m_cnt   = 0;
                end
            end
            if (flush && m_cnt > 0) begin
                sb.push_back('{data: m_lanes, count: 3'(m_cnt)});
                m_lanes = '0;
                m_cnt   = 0;
            end
        end
    end

    task automatic send_beat(input string tag);
        in_valid = 1'b1;
        in_data  = rnd_rec();
        @(negedge clk);
        check(tag, 512'(in_ready), ONE);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            tick();
        end
        check(tag, 512'(seen), ONE);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        done_seen = 0;
        m_lanes   = '0;
        m_cnt     = 0;
        reset_n   = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        check("rst_out_valid", 512'(out_valid), ZERO);
        check("rst_out_count", 512'(out_count), ZERO);
        check("rst_out_data", 512'(out_data), ZERO);
        check("rst_done", 512'(done), ZERO);
        check("rst_in_ready", 512'(in_ready), ONE);
        tick();
        reset_n = 1'b1;
        tick();

        // Full words at one beat per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = rnd_rec();
            @(negedge clk);
            check("stream_ready", 512'(in_ready), ONE);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("full_valid", 512'(out_valid), ONE);
        check("full_count", 512'(out_count), 512'd4);
        check("full_done", 512'(done), ZERO);
        tick();
        @(negedge clk);
        check("full_valid_drop", 512'(out_valid), ZERO);
        tick();

        // Backpressure: output register plus assembly register absorb eight beats
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat("bp_ready");
        in_valid = 1'b1;
        in_data  = rnd_rec();
        @(negedge clk);
        check("bp_full", 512'(in_ready), ZERO);
        tick();
        tick();
        @(negedge clk);
        check("bp_hold_ready", 512'(in_ready), ZERO);
        check("bp_hold_valid", 512'(out_valid), ONE);
        check("bp_hold_count", 512'(out_count), 512'd4);
        tick();
        out_ready = 1'b1;
        begin
            logic took;
            took = 1'b0;
            for (int i = 0; i < 10 && !took; i++) begin
                @(negedge clk);
                if (in_ready) took = 1'b1;
                if (in_ready) check("bp_b8_single_valid", 512'(out_valid), ONE);
                tick();
            end
            check("bp_b8_accept", 512'(took), ONE);
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        wait_done("b8_flush_done");
        repeat (2) tick();

        // Partial flush of two beats
        send_beat("c_ready");
        send_beat("c_ready");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("c_pend_ready", 512'(in_ready), ZERO);
        check("c_pend_valid", 512'(out_valid), ZERO);
        tick();
        @(negedge clk);
        check("c_valid", 512'(out_valid), ONE);
        check("c_count", 512'(out_count), 512'd2);
        check("c_done_early", 512'(done), ZERO);
        tick();
        @(negedge clk);
        check("c_done", 512'(done), ONE);
        check("c_valid_drop", 512'(out_valid), ZERO);
        tick();
        @(negedge clk);
        check("c_done_pulse", 512'(done), ZERO);
        tick();

        // Empty flush
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("e_pend_done", 512'(done), ZERO);
        check("e_pend_ready", 512'(in_ready), ZERO);
        tick();
        @(negedge clk);
        check("e_done", 512'(done), ONE);
        check("e_no_valid", 512'(out_valid), ZERO);
        tick();
        @(negedge clk);
        check("e_done_pulse", 512'(done), ZERO);
        check("e_no_valid2", 512'(out_valid), ZERO);
        tick();

        // Flush in the same cycle as the third beat
        send_beat("d_ready");
        send_beat("d_ready");
        in_valid = 1'b1;
        in_data  = rnd_rec();
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        tick();
        @(negedge clk);
        check("d_valid", 512'(out_valid), ONE);
        check("d_count", 512'(out_count), 512'd3);
        tick();
        @(negedge clk);
        check("d_done", 512'(done), ONE);
        tick();

        // Reset mid-packet with a stalled word pending
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_beat("g_ready");
        reset_n = 1'b0;
        @(negedge clk);
        check("mrst_out_valid", 512'(out_valid), ZERO);
        check("mrst_out_count", 512'(out_count), ZERO);
        check("mrst_out_data", 512'(out_data), ZERO);
        check("mrst_done", 512'(done), ZERO);
        check("mrst_in_ready", 512'(in_ready), ONE);
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) send_beat("e_ready");
        @(negedge clk);
        check("post_rst_valid", 512'(out_valid), ONE);
        check("post_rst_count", 512'(out_count), 512'd4);
        repeat (3) tick();

        @(negedge clk);
        check("sb_drained", 512'(sb.size()), ZERO);
        check("done_total", 512'(done_seen), 512'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/point_packer.md
# point_packer

Packs a stream of 128-bit point records into 512-bit point-cloud words, four records per word, with record 0 in bits [127:0]. It is the write-side counterpart of the tiler's point reader: point records produced upstream are re-assembled into the 512-bit format that the reader unpacks. Valid/ready handshakes on both sides and a flush input let a partial final word be emitted with a lane count.

## Interface
- DATA_W, 128, width of one point record
- LANES, 4, records per packed word; out_data width is DATA_W*LANES
- clk  input  1  single clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_data  input  DATA_W  point record
- in_valid  input  1  in_data valid
- in_ready  output  1  packer accepts in_data this cycle
- flush  input  1  single-cycle request to emit the partially filled word
- out_data  output  DATA_W*LANES  packed word; lane i at [DATA_W*i +: DATA_W]
- out_valid  output  1  out_data/out_count valid
- out_ready  input  1  downstream accepts out_data
- out_count  output  3  number of populated lanes (1..4)
- done  output  1  one-cycle pulse when a flush completes

## Operation
- State: assembly register asm (LANES lanes), lane counter cnt (0..4), output register (out_data, out_count, out_valid), flush_pend, flush_word.
- Beat accepted when in_valid && in_ready; in_data is written to lane cnt and cnt increments.
- in_ready = (cnt < 4) && !flush_pend, decoded from registers only.
- Slot free = !out_valid || out_ready.
- Full transfer: if the word is complete after this cycle's accept (cnt reaches 4) and the slot is free, load the output register with the completed word, out_count=4, out_valid=1, and clear asm to zero with cnt=0. If the slot is not free, hold with cnt=4 and in_ready=0; transfer on the first cycle the slot is free.
- Flush request: flush sets flush_pend the next cycle. A beat accepted in the same cycle as flush is included in the word. A flush arriving while flush_pend=1 is merged and ignored.
- Flush resolution runs when flush_pend=1 and the slot is free:
  - cnt > 0: load the output register with asm, out_count=cnt, unused lanes zero, set flush_word; clear asm, cnt, flush_pend.
  - cnt = 0: clear flush_pend; done pulses the next cycle; no output word.
- done pulses for one cycle, on the cycle after the output handshake of a word loaded with flush_word=1; flush_word clears at that handshake.
- The output register is held stable while out_valid && !out_ready.
- Words leave in the order their records entered. No record is dropped or duplicated.

## Timing
- Reset (reset_n low, asynchronous): out_data=0, out_count=0, out_valid=0, done=0, asm=0, cnt=0, flush_pend=0, flush_word=0. With these register values in_ready reads 1.
- Reset asserted mid-packet discards the partial word and any pending output. The first beat after reset lands in lane 0.
- Latency: 4th beat accepted at cycle N, out_valid=1 at N+1 when the slot is free at N.
- Throughput: one beat per cycle sustained with out_ready=1, giving one word every 4 cycles and no bubbles.
- Backpressure capacity: one word in the output register plus one full word in asm. in_ready falls the cycle after the 8th unconsumed beat.
- Empty flush: flush at T, flush_pend=1 at T+1, done=1 at T+2.
- Partial flush with a free slot: flush at T, out_valid=1 at T+2, done the cycle after the out handshake.
- Simultaneous events: an output handshake and a transfer in the same cycle reload the output register back-to-back, so out_valid stays 1.

## Test plan
- Beats A0..A3 on consecutive cycles, out_ready=1 -> one cycle after A3: out_data={A3,A2,A1,A0}, out_count=4, out_valid for 1 cycle, done=0.
- out_ready=0, offer 9 beats B0..B8 -> in_ready low after B7 and B8 held. Raise out_ready -> {B3..B0} then {B7..B4}, then B8 is accepted into lane 0.
- Beats C0,C1 then flush -> out_data lanes 0/1 = C0/C1, lanes 2/3 = 0, out_count=2. in_ready=0 while flush pending. done pulses the cycle after the handshake.
- flush with cnt=0 -> out_valid never asserts, done=1 exactly 2 cycles after flush.
- Flush in the same cycle as the 3rd beat D2 -> out_count=3 word {0,D2,D1,D0}.
- reset_n low for one cycle after 2 beats -> all outputs 0. A following E0..E3 produces {E3,E2,E1,E0} with out_count=4.
